// File: rtl/red_pkg.sv
// red_pkg: shared constants and FSM state type for the lane-serial RED engine
package red_pkg;
  localparam int LANE_W = 4;
  localparam int NUM_LANES = 4;
  localparam int ACC_W = 8;
  localparam int DATA_W = LANE_W * NUM_LANES;
  localparam int LIDX_W = $clog2(NUM_LANES);
  typedef enum logic [1:0] {RED_IDLE, RED_ACCUM, RED_DONE} redState_e;
endpackage

// File: rtl/red_lane_add.sv
// red_lane_add: adds the selected nibble lane of both operands into the running total
module red_lane_add
  import red_pkg::*;
(
  input  logic [DATA_W-1:0] aQ,
  input  logic [DATA_W-1:0] bQ,
  input  logic [LIDX_W-1:0] laneIdx,
  input  logic [ACC_W-1:0]  acc,
  output logic [ACC_W-1:0]  accNext
);
  logic [LANE_W-1:0] aLane;
  logic [LANE_W-1:0] bLane;
  // zero-extend both lane values before summing so the carry lands in the accumulator
  always_comb begin
    aLane = aQ[laneIdx*LANE_W +: LANE_W];
    bLane = bQ[laneIdx*LANE_W +: LANE_W];
    accNext = acc + ACC_W'(aLane) + ACC_W'(bLane);
  end
endmodule

// File: rtl/red_serial.sv
// red_serial: multicycle RED responder, one nibble lane per cycle, one-cycle done pulse
module red_serial
  import red_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              flush,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum
);
  redState_e state;
  redState_e nextState;
  logic [DATA_W-1:0] aQ;
  logic [DATA_W-1:0] bQ;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] accNext;
  logic [LIDX_W-1:0] laneIdx;
  logic lastLane;
  logic accept;
  assign lastLane = laneIdx == LIDX_W'(NUM_LANES - 1);
  assign accept = start && !flush && state != RED_ACCUM;
  red_lane_add u_laneAdd (
    .aQ(aQ),
    .bQ(bQ),
    .laneIdx(laneIdx),
    .acc(acc),
    .accNext(accNext)
  );
  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RED_IDLE;
    else state <= nextState;
  end
  // flush wins over everything; DONE re-accepts start for back-to-back issue
  always_comb begin
    nextState = flush ? RED_IDLE
              : accept ? RED_ACCUM
              : state == RED_ACCUM ? (lastLane ? RED_DONE : RED_ACCUM)
              : RED_IDLE;
  end
  // handshake outputs decode straight from the registered state
  always_comb begin
    busy = state == RED_ACCUM;
    done = state == RED_DONE;
  end
  // operand capture, lane accumulation, and result update on the final lane only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aQ <= '0;
      bQ <= '0;
      acc <= '0;
      laneIdx <= '0;
      sum <= '0;
    end else if (flush) begin
      laneIdx <= '0;
    end else if (accept) begin
      aQ <= a;
      bQ <= b;
      acc <= '0;
      laneIdx <= '0;
    end else if (state == RED_ACCUM) begin
      acc <= accNext;
      laneIdx <= laneIdx + LIDX_W'(1);
      if (lastLane) sum <= {{(DATA_W - ACC_W){1'b0}}, accNext};
    end
  end
endmodule

// File: tb/tb_red_serial.sv
// tb_red_serial: randomized and directed checks of red_serial against a cycle-level result model
module tb_red_serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic flush = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic busy;
  logic done;
  logic [15:0] sum;
  int checks = 0;
  int errors = 0;
  int mLeft;
  logic mDone;
  logic [15:0] mSum;
  logic [15:0] mRes;
  int doneCount;

  red_serial dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .a(a),
    .b(b),
    .flush(flush),
    .busy(busy),
    .done(done),
    .sum(sum)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] nibSum(input logic [15:0] x, input logic [15:0] y);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'((x >> (4 * i)) & 16'hF) + int'((y >> (4 * i)) & 16'hF);
    return 16'(s);
  endfunction

  task automatic modelReset();
    mLeft = 0;
    mDone = 1'b0;
    mSum = '0;
    mRes = '0;
  endtask

  task automatic checkAll(input string tag);
    check({tag, ".busy"}, 16'(busy), 16'(mLeft > 0));
    check({tag, ".done"}, 16'(done), 16'(mDone));
    check({tag, ".sum"}, sum, mSum);
  endtask

  task automatic step(input string tag, input logic s, input logic f, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start = s;
    flush = f;
    a = x;
    b = y;
    @(posedge clk);
    if (f) begin
      mLeft = 0;
      mDone = 1'b0;
    end else if (mLeft > 0) begin
      mLeft--;
      mDone = mLeft == 0;
      if (mDone) mSum = mRes;
    end else begin
      mDone = 1'b0;
      if (s) begin
        mRes = nibSum(x, y);
        mLeft = 4;
      end
    end
    #1;
    checkAll(tag);
    if (done) doneCount++;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 16'(i * 37), 16'(i * 91));
  endtask

  initial begin
    modelReset();
    doneCount = 0;
    repeat (2) @(posedge clk);
    #1;
    checkAll("reset");
    @(negedge clk);
    rst_n = 1'b1;

    step("op1234", 1'b1, 1'b0, 16'h1234, 16'h5678);
    idle("op1234", 4);
    check("op1234.donePulse", 16'(done), 16'd1);
    check("op1234.result", sum, 16'h0024);
    idle("op1234.after", 1);

    step("opFFFF", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    idle("opFFFF", 4);
    check("opFFFF.result", sum, 16'h0078);
    check("opFFFF.upper", 16'(sum[15:8]), 16'h0000);
    idle("opFFFF.after", 1);

    step("b2b1", 1'b1, 1'b0, 16'h0001, 16'h0002);
    idle("b2b1", 4);
    check("b2b1.result", sum, 16'h0003);
    step("b2b2", 1'b1, 1'b0, 16'h00F0, 16'h0F00);
    check("b2b2.accepted", 16'(busy), 16'd1);
    idle("b2b2", 4);
    check("b2b2.done", 16'(done), 16'd1);
    check("b2b2.result", sum, 16'h001E);
    idle("b2b2.after", 1);

    doneCount = 0;
    step("ignore", 1'b1, 1'b0, 16'h1111, 16'h0000);
    idle("ignore", 1);
    step("ignore.start", 1'b1, 1'b0, 16'hFFFF, 16'h0000);
    idle("ignore", 5);
    check("ignore.result", sum, 16'h0004);
    check("ignore.pulses", 16'(doneCount), 16'd1);

    step("flush.pre", 1'b1, 1'b0, 16'h1234, 16'h5678);
    idle("flush.pre", 5);
    doneCount = 0;
    step("flush.op", 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    idle("flush.op", 2);
    step("flush.hit", 1'b0, 1'b1, 16'h0, 16'h0);
    check("flush.sumHeld", sum, 16'h0024);
    idle("flush.after", 5);
    check("flush.noDone", 16'(doneCount), 16'd0);
    step("flushStart", 1'b1, 1'b1, 16'hFFFF, 16'hFFFF);
    check("flushStart.idle", 16'(busy), 16'd0);
    idle("flushStart.after", 5);
    check("flushStart.noDone", 16'(doneCount), 16'd0);

    step("rstMid", 1'b1, 1'b0, 16'hABCD, 16'h1234);
    idle("rstMid", 1);
    #3;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll("rstMid.async");
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    idle("rstMid.after", 6);
    check("rstMid.noDone", 16'(doneCount), 16'd0);

    for (int i = 0; i < 400; i++) begin
      logic [15:0] ra;
      logic [15:0] rb;
      ra = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      step("rand", $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/red_serial.md
Name: red_serial

Overview:
- Multi-cycle, lane-serial RED engine. It is the responder side of the EX-stage multicycle-op handshake.
- The ALU (initiator) pulses `start` with operands A and B.
- The engine walks four 4-bit nibble lanes, one per cycle, and accumulates A_lane + B_lane. It returns the zero-extended total with a one-cycle `done` pulse.
- Used where the single-cycle adder tree does not meet timing. It is result-compatible with the combinational RED result.

Parameters:
- LANE_W, 4, width of one nibble lane.
- NUM_LANES, 4, number of lanes; LANE_W*NUM_LANES must equal 16.
- ACC_W, 8, accumulator width; must hold NUM_LANES*2*(2^LANE_W-1), which is 120 at defaults.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request pulse from ALU; accepted only in IDLE or DONE.
- a  in  16  operand A; sampled on the accepting edge.
- b  in  16  operand B; sampled on the accepting edge.
- flush  in  1  synchronous pipeline-flush abort.
- busy  out  1  high while the op is in flight (ACCUM).
- done  out  1  registered one-cycle completion pulse.
- sum  out  16  result; {8'h00, acc[7:0]}; held between ops.

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE, busy=0, done=0, sum=16'h0000.
  - Accumulator, lane index and operand registers are cleared.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - On an edge where start=1 and flush=0, latch a and b, clear acc and lane_idx, and go to ACCUM.
  - busy becomes 1 after that edge.
- ACCUM:
  - Each edge performs acc <= acc + {0,a_q[lane]} + {0,b_q[lane]}, where the two lane values are zero-extended to ACC_W.
  - lane_idx increments on each of these edges.
  - On the edge processing lane NUM_LANES-1:
    - load sum with the final accumulated value;
    - set done=1 and busy=0;
    - go to DONE.
  - Lane order is 0 to 3, starting with the LSB nibble.
- DONE:
  - done is high for exactly this one cycle.
  - The next edge returns to IDLE, unless start=1, in which case the new op is accepted and the state goes straight to ACCUM (back-to-back).
- Latency: start accepted at edge k; done is high in the cycle following edge k+NUM_LANES (k+4 at defaults). Issue interval is 5 cycles with back-to-back starts.
- start while in ACCUM: ignored. No queuing; a_q/b_q are not overwritten.
- flush:
  - Has priority over start and over accumulation.
  - Any state goes to IDLE on the next edge with busy=0 and done=0.
  - sum keeps its previous completed value.
  - flush and start on the same edge: start is dropped.
- Arithmetic:
  - Each lane pair contributes 0..30; the maximum total is 120. There is no overflow in ACC_W=8.
  - sum[15:8] is always 0.
- sum changes only on the completing edge and on reset. It is stable at all other times, including during a subsequent op.
- Reset asserted mid-op: outputs go to reset values immediately (asynchronously). No done pulse is produced for the aborted op.

Decomposition:
- Package red_pkg:
  - LANE_W, NUM_LANES, ACC_W constants;
  - state enum {RED_IDLE, RED_ACCUM, RED_DONE};
  - a localparam for lane_idx width = clog2(NUM_LANES).
- Sub-module red_lane_add:
  - combinational;
  - selects lane lane_idx from a_q and b_q;
  - produces acc + zext(a_lane) + zext(b_lane).
- Top red_serial holds the FSM, operand, accumulator and output registers.

Test Plan:
- Reset: hold rst_n=0 then release -> sum=0x0000, busy=0, done=0. Assert rst_n low mid-ACCUM -> outputs zero immediately and no done pulse follows.
- a=0x1234, b=0x5678, start at edge k:
  - busy is high during cycles k+1..k+4;
  - done pulses one cycle after edge k+4;
  - sum=0x0024 (lane sums 12+10+8+6=36).
- a=0xFFFF, b=0xFFFF -> sum=0x0078; upper byte 0x00.
- Back-to-back ops:
  - first op a=0x0001, b=0x0002 -> sum=0x0003 with done;
  - start in the DONE cycle with a=0x00F0, b=0x0F00 -> accepted immediately; second done 5 cycles after the first; sum=0x001E.
- start=1 with a=0xFFFF during the 2nd ACCUM cycle of op a=0x1111, b=0x0000 -> ignored; result 0x0004; a single done pulse.
- Flush:
  - complete an op producing 0x0024;
  - start a new op and assert flush in its 3rd ACCUM cycle -> IDLE next edge, busy=0, no done, sum stays 0x0024;
  - flush and start on the same edge -> no op starts.
